// File: rtl/snake_core.sv
`default_nettype none
// ============================================================================
// Module   : snake_core
// Purpose  : Snake game engine on a GRID_W x GRID_H board. The body is kept
//            as a coordinate ring buffer and mirrored in an occupancy bitmap.
//            Apples are placed by a bounded linear search that starts from a
//            random cell. A combinational read port serves the pixel renderer.
// Config   : define SNAKE_WRAP_EN to make the walls wrap around. With the
//            macro undefined, leaving the board ends the game.
// Revision : 1.0 - initial release
// ============================================================================
module snake_core #(
  parameter int GRID_W  = 10,
  parameter int GRID_H  = 10,
  parameter int XW      = 4,
  parameter int YW      = 4,
  parameter int LW      = 8,
  parameter int START_X = 5,
  parameter int START_Y = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          tick,
  input  logic [3:0]    dir_req,
  input  logic [7:0]    rnd,
  input  logic [XW-1:0] rd_x,
  input  logic [YW-1:0] rd_y,
  output logic [1:0]    rd_cell,
  output logic [XW-1:0] head_x,
  output logic [YW-1:0] head_y,
  output logic [1:0]    head_dir,
  output logic [LW-1:0] length,
  output logic [XW-1:0] apple_x,
  output logic [YW-1:0] apple_y,
  output logic          apple_vld,
  output logic          game_over,
  output logic          win,
  output logic          busy
);

  // Board size, linear-index width (one spare bit) and ring pointer width
  localparam int c_cells = GRID_W * GRID_H;
  localparam int c_iw    = $clog2(c_cells) + 1;
  localparam int c_pw    = $clog2(c_cells);

  localparam logic [c_iw-1:0]    c_last_idx   = c_iw'(c_cells - 1);
  localparam logic [c_pw-1:0]    c_last_ptr   = c_pw'(c_cells - 1);
  localparam logic [LW-1:0]      c_full_len   = LW'(c_cells);
  localparam logic [XW-1:0]      c_max_x      = XW'(GRID_W - 1);
  localparam logic [YW-1:0]      c_max_y      = YW'(GRID_H - 1);
  localparam logic [XW-1:0]      c_start_x    = XW'(START_X);
  localparam logic [YW-1:0]      c_start_y    = YW'(START_Y);
  localparam logic [c_cells-1:0] c_start_mask = c_cells'(1) << (START_Y * GRID_W + START_X);

`ifdef SNAKE_WRAP_EN
  localparam bit c_wrap = 1'b1;
`else
  localparam bit c_wrap = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_SPAWN = 2'd0,
    ST_RUN   = 2'd1,
    ST_DEAD  = 2'd2,
    ST_WIN   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [XW-1:0]      r_head_x;
  logic [YW-1:0]      r_head_y;
  logic [1:0]         r_head_dir;
  logic [1:0]         r_pend_dir;
  logic [LW-1:0]      r_len;
  logic [XW-1:0]      r_apple_x;
  logic [YW-1:0]      r_apple_y;
  logic               r_apple_vld;
  logic [c_cells-1:0] r_occ;
  logic [XW-1:0]      r_ring_x [c_cells];
  logic [YW-1:0]      r_ring_y [c_cells];
  logic [c_pw-1:0]    r_hptr;
  logic [c_pw-1:0]    r_tptr;
  logic [c_iw-1:0]    r_cand;
  logic               r_first;

  logic               w_dir_vld;
  logic [1:0]         w_dir_code;
  logic [XW-1:0]      w_nx;
  logic [YW-1:0]      w_ny;
  logic               w_off;
  logic               w_wall_hit;
  logic [c_iw-1:0]    w_nidx;
  logic [c_iw-1:0]    w_tidx;
  logic               w_eat;
  logic               w_hit;
  logic               w_die;
  logic               w_full;
  logic [c_iw-1:0]    w_rmod;
  logic [c_iw-1:0]    w_cand;
  logic               w_cand_free;
  logic [XW-1:0]      w_cand_x;
  logic [YW-1:0]      w_cand_y;
  logic [c_pw-1:0]    w_hptr_inc;
  logic [c_pw-1:0]    w_tptr_inc;
  logic [c_iw-1:0]    w_rd_idx;
  logic               w_rd_in;

  // Linear cell index y*GRID_W + x, never truncated below the cell count
  function automatic logic [c_iw-1:0] f_idx(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return c_iw'(y) * c_iw'(GRID_W) + c_iw'(x);
  endfunction

  // Ring pointer increment with wrap at the board size
  function automatic logic [c_pw-1:0] f_inc(input logic [c_pw-1:0] p);
    return (p == c_last_ptr) ? '0 : p + 1'b1;
  endfunction

  // Decode the one-hot key request; any other code is ignored
  always_comb begin
    w_dir_vld  = 1'b1;
    w_dir_code = 2'b00;
    case (dir_req)
      4'b0001: w_dir_code = 2'b00;
      4'b0010: w_dir_code = 2'b01;
      4'b0100: w_dir_code = 2'b10;
      4'b1000: w_dir_code = 2'b11;
      default: w_dir_vld  = 1'b0;
    endcase
  end

  // Next head cell; on a wall crossing the wrapped cell is produced and flagged
  always_comb begin
    w_nx  = r_head_x;
    w_ny  = r_head_y;
    w_off = 1'b0;
    case (r_pend_dir)
      2'b00: begin
        if (r_head_y == '0) begin
          w_off = 1'b1;
          w_ny  = c_max_y;
        end else begin
          w_ny  = r_head_y - 1'b1;
        end
      end
      2'b01: begin
        if (r_head_y == c_max_y) begin
          w_off = 1'b1;
          w_ny  = '0;
        end else begin
          w_ny  = r_head_y + 1'b1;
        end
      end
      2'b10: begin
        if (r_head_x == '0) begin
          w_off = 1'b1;
          w_nx  = c_max_x;
        end else begin
          w_nx  = r_head_x - 1'b1;
        end
      end
      default: begin
        if (r_head_x == c_max_x) begin
          w_off = 1'b1;
          w_nx  = '0;
        end else begin
          w_nx  = r_head_x + 1'b1;
        end
      end
    endcase
  end

  // The tail cell may be entered only when it vacates in the same step (no eat)
  assign w_wall_hit  = c_wrap ? 1'b0 : w_off;
  assign w_nidx      = f_idx(w_nx, w_ny);
  assign w_tidx      = f_idx(r_ring_x[r_tptr], r_ring_y[r_tptr]);
  assign w_eat       = r_apple_vld && (w_nx == r_apple_x) && (w_ny == r_apple_y);
  assign w_hit       = r_occ[w_nidx[c_pw-1:0]] && !((w_nidx == w_tidx) && !w_eat);
  assign w_die       = w_wall_hit || w_hit;
  assign w_full      = (r_len == c_full_len);
  assign w_hptr_inc  = f_inc(r_hptr);
  assign w_tptr_inc  = f_inc(r_tptr);

  // Apple search: the first probe uses the live random value, later probes step by one
  assign w_rmod      = c_iw'(32'(rnd) % 32'(c_cells));
  assign w_cand      = r_first ? w_rmod : r_cand;
  assign w_cand_free = !r_occ[w_cand[c_pw-1:0]];
  assign w_cand_x    = XW'(w_cand % c_iw'(GRID_W));
  assign w_cand_y    = YW'(w_cand / c_iw'(GRID_W));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_SPAWN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a start pulse wins over everything else
  always_comb begin
    w_state_nxt = r_state;
    if (start) begin
      w_state_nxt = ST_SPAWN;
    end else begin
      case (r_state)
        ST_SPAWN: begin
          if (w_full) begin
            w_state_nxt = ST_WIN;
          end else if (w_cand_free) begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_RUN: begin
          if (tick) begin
            if (w_die) begin
              w_state_nxt = ST_DEAD;
            end else if (w_eat) begin
              w_state_nxt = ST_SPAWN;
            end
          end
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // Snake body, direction, apple and search datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head_x    <= c_start_x;
      r_head_y    <= c_start_y;
      r_head_dir  <= 2'b11;
      r_pend_dir  <= 2'b11;
      r_len       <= LW'(1);
      r_apple_x   <= '0;
      r_apple_y   <= '0;
      r_apple_vld <= 1'b0;
      r_occ       <= c_start_mask;
      r_ring_x[0] <= c_start_x;
      r_ring_y[0] <= c_start_y;
      r_hptr      <= '0;
      r_tptr      <= '0;
      r_cand      <= '0;
      r_first     <= 1'b1;
    end else if (start) begin
      r_head_x    <= c_start_x;
      r_head_y    <= c_start_y;
      r_head_dir  <= 2'b11;
      r_pend_dir  <= 2'b11;
      r_len       <= LW'(1);
      r_apple_x   <= '0;
      r_apple_y   <= '0;
      r_apple_vld <= 1'b0;
      r_occ       <= c_start_mask;
      r_ring_x[0] <= c_start_x;
      r_ring_y[0] <= c_start_y;
      r_hptr      <= '0;
      r_tptr      <= '0;
      r_cand      <= '0;
      r_first     <= 1'b1;
    end else begin
      // Requests only matter while the game is live; reversals are dropped
      if (((r_state == ST_SPAWN) || (r_state == ST_RUN)) && w_dir_vld &&
          (w_dir_code != (r_head_dir ^ 2'b01))) begin
        r_pend_dir <= w_dir_code;
      end
      case (r_state)
        ST_SPAWN: begin
          if (!w_full) begin
            r_first <= 1'b0;
            if (w_cand_free) begin
              r_apple_x   <= w_cand_x;
              r_apple_y   <= w_cand_y;
              r_apple_vld <= 1'b1;
            end else begin
              r_cand <= (w_cand == c_last_idx) ? '0 : w_cand + 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (tick && !w_die) begin
            r_head_x           <= w_nx;
            r_head_y           <= w_ny;
            r_head_dir         <= r_pend_dir;
            r_hptr             <= w_hptr_inc;
            r_ring_x[w_hptr_inc] <= w_nx;
            r_ring_y[w_hptr_inc] <= w_ny;
            if (w_eat) begin
              r_len       <= r_len + 1'b1;
              r_apple_vld <= 1'b0;
              r_first     <= 1'b1;
            end else begin
              r_tptr               <= w_tptr_inc;
              r_occ[w_tidx[c_pw-1:0]] <= 1'b0;
            end
            // Set after the tail clear so a head entering the vacated tail stays marked
            r_occ[w_nidx[c_pw-1:0]] <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Renderer query: head over body over apple; off-board cells read empty
  assign w_rd_idx = f_idx(rd_x, rd_y);
  assign w_rd_in  = ({1'b0, rd_x} < (XW + 1)'(GRID_W)) &&
                    ({1'b0, rd_y} < (YW + 1)'(GRID_H)) &&
                    (w_rd_idx <= c_last_idx);

  always_comb begin
    rd_cell = 2'b00;
    if (w_rd_in) begin
      if ((rd_x == r_head_x) && (rd_y == r_head_y)) begin
        rd_cell = 2'b10;
      end else if (r_occ[w_rd_idx[c_pw-1:0]]) begin
        rd_cell = 2'b01;
      end else if (r_apple_vld && (rd_x == r_apple_x) && (rd_y == r_apple_y)) begin
        rd_cell = 2'b11;
      end
    end
  end

  assign head_x    = r_head_x;
  assign head_y    = r_head_y;
  assign head_dir  = r_head_dir;
  assign length    = r_len;
  assign apple_x   = r_apple_x;
  assign apple_y   = r_apple_y;
  assign apple_vld = r_apple_vld;
  assign busy      = (r_state == ST_SPAWN);
  assign game_over = (r_state == ST_DEAD);
  assign win       = (r_state == ST_WIN);

endmodule
`default_nettype wire

// File: tb/tb_snake_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_snake_core
// Purpose  : Self-checking bench for snake_core: directed scenarios plus a
//            randomized game checked against a queue-based game model, and a
//            2x2 board instance driven to a win.
// Revision : 1.0 - initial release
// ============================================================================
module tb_snake_core;

  localparam int W     = 10;
  localparam int H     = 10;
  localparam int CELLS = W * H;
  localparam int SX    = 5;
  localparam int SY    = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, tick = 1'b0;
  logic [3:0] dir_req = 4'd0;
  logic [7:0] rnd = 8'd0;
  logic [3:0] rd_x = 4'd0, rd_y = 4'd0;
  logic [1:0] rd_cell, head_dir;
  logic [3:0] head_x, head_y, apple_x, apple_y;
  logic [7:0] length;
  logic       apple_vld, game_over, win, busy;

  logic       s2_start = 1'b0, s2_tick = 1'b0;
  logic [3:0] s2_dir = 4'd0;
  logic [7:0] s2_rnd = 8'd0;
  logic [3:0] s2_rd_x = 4'd0, s2_rd_y = 4'd0;
  logic [1:0] s2_rd_cell, s2_head_dir;
  logic [3:0] s2_head_x, s2_head_y, s2_apple_x, s2_apple_y;
  logic [7:0] s2_length;
  logic       s2_apple_vld, s2_game_over, s2_win, s2_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  snake_core dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tick(tick), .dir_req(dir_req), .rnd(rnd),
    .rd_x(rd_x), .rd_y(rd_y), .rd_cell(rd_cell), .head_x(head_x), .head_y(head_y),
    .head_dir(head_dir), .length(length), .apple_x(apple_x), .apple_y(apple_y),
    .apple_vld(apple_vld), .game_over(game_over), .win(win), .busy(busy)
  );

  snake_core #(.GRID_W(2), .GRID_H(2), .START_X(0), .START_Y(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(s2_start), .tick(s2_tick), .dir_req(s2_dir), .rnd(s2_rnd),
    .rd_x(s2_rd_x), .rd_y(s2_rd_y), .rd_cell(s2_rd_cell), .head_x(s2_head_x), .head_y(s2_head_y),
    .head_dir(s2_head_dir), .length(s2_length), .apple_x(s2_apple_x), .apple_y(s2_apple_y),
    .apple_vld(s2_apple_vld), .game_over(s2_game_over), .win(s2_win), .busy(s2_busy)
  );

  // ---------------- game model (10x10 instance) ----------------
  // state: 0 searching, 1 running, 2 dead, 3 won
  int q[$];           // snake cells as linear indices, q[0] is the head
  int m_state, m_apple, m_hd, m_pd, m_target, m_rem;
  bit m_avld, m_have;

  function automatic bit on_snake(int c);
    foreach (q[i]) if (q[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    q.delete();
    q.push_back(SY * W + SX);
    m_state = 0; m_avld = 0; m_hd = 3; m_pd = 3; m_have = 0; m_apple = 0;
  endtask

  task automatic model_step(bit st, bit tk, logic [3:0] dr, logic [7:0] rn);
    int ohd, ost, nx, ny, n, c, k, d;
    bit eat;
    if (st) begin model_reset(); return; end
    ohd = m_hd; ost = m_state;
    if (ost == 0) begin
      if (q.size() == CELLS) m_state = 3;
      else begin
        if (!m_have) begin
          c = int'(rn) % CELLS; k = 1;
          while (on_snake(c)) begin c = (c + 1) % CELLS; k++; end
          m_target = c; m_rem = k; m_have = 1;
        end
        m_rem--;
        if (m_rem == 0) begin m_apple = m_target; m_avld = 1; m_state = 1; m_have = 0; end
      end
    end else if (ost == 1 && tk) begin
      nx = q[0] % W; ny = q[0] / W;
      case (m_pd)
        0: ny--;
        1: ny++;
        2: nx--;
        default: nx++;
      endcase
`ifdef SNAKE_WRAP_EN
      nx = (nx + W) % W; ny = (ny + H) % H;
`endif
      if (nx < 0 || nx >= W || ny < 0 || ny >= H) m_state = 2;
      else begin
        n = ny * W + nx;
        eat = m_avld && (n == m_apple);
        if (on_snake(n) && !(n == q[$] && !eat)) m_state = 2;
        else begin
          if (!eat) void'(q.pop_back());
          q.push_front(n);
          m_hd = m_pd;
          if (eat) begin m_avld = 0; m_state = 0; m_have = 0; end
        end
      end
    end
    case (dr)
      4'b0001: d = 0;
      4'b0010: d = 1;
      4'b0100: d = 2;
      4'b1000: d = 3;
      default: d = -1;
    endcase
    if ((ost == 0 || ost == 1) && d >= 0 && d != (ohd ^ 1)) m_pd = d;
  endtask

  function automatic int m_cell(int qx, int qy);
    int c;
    if (qx >= W || qy >= H) return 0;
    c = qy * W + qx;
    if (c == q[0]) return 2;
    if (on_snake(c)) return 1;
    if (m_avld && c == m_apple) return 3;
    return 0;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("head_x", 32'(head_x), 32'(q[0] % W));
    chk("head_y", 32'(head_y), 32'(q[0] / W));
    chk("length", 32'(length), 32'(q.size()));
    chk("head_dir", 32'(head_dir), 32'(m_hd));
    chk("busy", 32'(busy), 32'(m_state == 0));
    chk("game_over", 32'(game_over), 32'(m_state == 2));
    chk("win", 32'(win), 32'(m_state == 3));
    chk("apple_vld", 32'(apple_vld), 32'(m_avld));
    if (m_avld) begin
      chk("apple_x", 32'(apple_x), 32'(m_apple % W));
      chk("apple_y", 32'(apple_y), 32'(m_apple / W));
    end
    chk("rd_cell", 32'(rd_cell), 32'(m_cell(int'(rd_x), int'(rd_y))));
  endtask

  // One clock: drive at negedge, model at posedge, check at the next negedge
  task automatic step(bit st, bit tk, logic [3:0] dr, logic [7:0] rn, int qx, int qy);
    start = st; tick = tk; dir_req = dr; rnd = rn; rd_x = qx[3:0]; rd_y = qy[3:0];
    @(posedge clk);
    model_step(st, tk, dr, rn);
    @(negedge clk);
    check_all();
    start = 1'b0; tick = 1'b0; dir_req = 4'd0;
  endtask

  task automatic settle(logic [7:0] rn);
    int n = 0;
    while (m_state == 0 && n < 300) begin
      step(1'b0, 1'b0, 4'd0, rn, 0, 0);
      n++;
    end
    chk("spawn_done", 32'(busy), 32'd0);
  endtask

  task automatic step2(bit st, bit tk, logic [3:0] dr, logic [7:0] rn);
    s2_start = st; s2_tick = tk; s2_dir = dr; s2_rnd = rn;
    @(posedge clk);
    @(negedge clk);
    s2_start = 1'b0; s2_tick = 1'b0; s2_dir = 4'd0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] dr;
    bit st, tk;
    model_reset();
    repeat (3) @(negedge clk);
    check_all();
    chk("reset_busy", 32'(busy), 32'd1);
    chk("reset_len", 32'(length), 32'd1);
    rst_n = 1'b1;

    // First apple from rnd=37 -> (7,3) after a single busy cycle
    step(0, 0, 4'd0, 8'd37, 5, 5);
    chk("apple37_x", 32'(apple_x), 32'd7);
    chk("apple37_y", 32'(apple_y), 32'd3);
    chk("head_cell", 32'(rd_cell), 32'd2);

    // Run right into the east wall
    for (int i = 0; i < 4; i++) step(0, 1, 4'd0, 8'd0, 9, 5);
    chk("east_x", 32'(head_x), 32'd9);
    step(0, 1, 4'd0, 8'd0, 0, 5);
`ifdef SNAKE_WRAP_EN
    chk("wrap_x", 32'(head_x), 32'd0);
    chk("wrap_alive", 32'(game_over), 32'd0);
`else
    chk("wall_dead", 32'(game_over), 32'd1);
    step(0, 1, 4'b0001, 8'd0, 9, 5);
    chk("frozen_x", 32'(head_x), 32'd9);
`endif

    // Eat at (6,5), then grow into a 2x2 loop and step into the vacating tail
    step(1, 1, 4'd0, 8'd0, 0, 0);
    step(0, 0, 4'd0, 8'd56, 6, 5);
    chk("apple56", 32'(rd_cell), 32'd3);
    step(0, 1, 4'd0, 8'd0, 5, 5);
    chk("eat_len", 32'(length), 32'd2);
    chk("eat_busy", 32'(busy), 32'd1);
    chk("eat_body", 32'(rd_cell), 32'd1);
    settle(8'd66);
    step(0, 0, 4'b0010, 8'd0, 0, 0);
    step(0, 1, 4'd0, 8'd0, 0, 0);
    settle(8'd65);
    step(0, 0, 4'b0100, 8'd0, 0, 0);
    step(0, 1, 4'd0, 8'd0, 0, 0);
    chk("loop_len", 32'(length), 32'd4);
    settle(8'd0);
    step(0, 0, 4'b0001, 8'd0, 0, 0);
    step(0, 1, 4'd0, 8'd0, 5, 5);
    chk("tail_alive", 32'(game_over), 32'd0);
    chk("tail_x", 32'(head_x), 32'd5);
    chk("tail_y", 32'(head_y), 32'd5);
    chk("tail_len", 32'(length), 32'd4);

    // Reversal request is dropped; an up request moves y down by one
    step(1, 0, 4'd0, 8'd0, 0, 0);
    step(0, 0, 4'd0, 8'd37, 0, 0);
    step(0, 0, 4'b0100, 8'd0, 0, 0);
    step(0, 1, 4'd0, 8'd0, 0, 0);
    chk("norev_x", 32'(head_x), 32'd6);
    step(0, 0, 4'b0001, 8'd0, 0, 0);
    step(0, 1, 4'd0, 8'd0, 0, 0);
    chk("up_y", 32'(head_y), 32'd4);

    // Asynchronous reset mid-game
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized play
    for (int i = 0; i < 1500; i++) begin
      st = ((m_state >= 2) && ($urandom % 3 == 0)) || ($urandom % 400 == 0);
      tk = !st && ($urandom % 3 == 0);
      dr = 4'd0;
      if (!tk && ($urandom % 3 == 0))
        dr = ($urandom % 5 == 0) ? 4'($urandom) : 4'(4'b0001 << ($urandom % 4));
      if ($urandom % 2 == 0)
        step(st, tk, dr, 8'($urandom), q[0] % W + ($urandom % 3) - 1, q[0] / W + ($urandom % 3) - 1);
      else
        step(st, tk, dr, 8'($urandom), int'($urandom % 16), int'($urandom % 16));
    end

    // 2x2 board: fill it and win, then inputs are ignored until start
    step2(1, 0, 4'd0, 8'd0);
    step2(0, 0, 4'd0, 8'd1);
    chk("s2_apple_x", 32'(s2_apple_x), 32'd1);
    chk("s2_apple_y", 32'(s2_apple_y), 32'd0);
    step2(0, 1, 4'd0, 8'd0);
    chk("s2_len2", 32'(s2_length), 32'd2);
    step2(0, 0, 4'd0, 8'd3);
    step2(0, 0, 4'b0010, 8'd0);
    step2(0, 1, 4'd0, 8'd0);
    chk("s2_len3", 32'(s2_length), 32'd3);
    step2(0, 0, 4'd0, 8'd2);
    chk("s2_apple_last", 32'(s2_apple_x), 32'd0);
    step2(0, 0, 4'b0100, 8'd0);
    step2(0, 1, 4'd0, 8'd0);
    chk("s2_len4", 32'(s2_length), 32'd4);
    step2(0, 0, 4'd0, 8'd0);
    chk("s2_win", 32'(s2_win), 32'd1);
    chk("s2_notbusy", 32'(s2_busy), 32'd0);
    step2(0, 1, 4'd0, 8'd0);
    step2(0, 0, 4'b0001, 8'd0);
    step2(0, 1, 4'd0, 8'd0);
    chk("s2_hold_x", 32'(s2_head_x), 32'd0);
    chk("s2_hold_y", 32'(s2_head_y), 32'd1);
    chk("s2_hold_win", 32'(s2_win), 32'd1);
    chk("s2_hold_dir", 32'(s2_head_dir), 32'd2);
    step2(1, 0, 4'd0, 8'd0);
    chk("s2_restart_win", 32'(s2_win), 32'd0);
    chk("s2_restart_len", 32'(s2_length), 32'd1);
    chk("s2_restart_busy", 32'(s2_busy), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
